// File: rtl/abs_diff_eval_pkg.sv
// Shared definitions for the |a-b| error-sweep controller:
// sweep states, default widths and a width-generic saturating adder.
package abs_diff_eval_pkg;

    localparam int W_DEF     = 4;
    localparam int ACC_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Adds two values and clamps the result to the all-ones value of a
    // 'width'-bit accumulator (width must be 1..32).
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] cap;
        sum = {1'b0, acc} + {1'b0, inc};
        cap = (33'd1 << width) - 33'd1;
        return (sum > cap) ? cap[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/abs_err_unit.sv
// Combinational absolute difference |x-y| on W-bit unsigned operands.
module abs_err_unit #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] d
);

    // Subtract the smaller operand from the larger so the result never wraps
    always_comb begin
        d = (x >= y) ? (x - y) : (y - x);
    end

endmodule

// File: rtl/abs_diff_err_sweep_ctrl.sv
// Exhaustive sweep sequencer: walks every (a,b) pair through an exact and an
// approximate |a-b| datapath and accumulates error count, saturating error
// sum, maximum error and the earliest vector that produced that maximum.
module abs_diff_err_sweep_ctrl
    import abs_diff_eval_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [W-1:0]     res_exact,
    input  logic [W-1:0]     res_apx,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] err_count,
    output logic [ACC_W-1:0] err_sum,
    output logic [W-1:0]     err_max,
    output logic [2*W-1:0]   max_vec
);

    state_t           state_reg;
    state_t           state_next;
    logic [2*W-1:0]   vec_reg;
    logic [ACC_W-1:0] err_count_reg;
    logic [ACC_W-1:0] err_sum_reg;
    logic [W-1:0]     err_max_reg;
    logic [2*W-1:0]   max_vec_reg;

    logic [W-1:0]     err;
    logic             start_go;
    logic             accum;
    logic             last_vec;

    abs_err_unit #(.W(W)) u_err (
        .x (res_exact),
        .y (res_apx),
        .d (err)
    );

    // start is honoured only outside SWEEP; abort outranks pause
    assign start_go = (state_reg != SWEEP) && start;
    assign accum    = (state_reg == SWEEP) && !pause && !abort;
    assign last_vec = &vec_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: sweep ends once the final vector has been accumulated
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SWEEP;
            SWEEP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accum && last_vec) begin
                    state_next = DONE;
                end
            end
            DONE:    if (start) state_next = SWEEP;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state_reg == SWEEP);
        done = (state_reg == DONE);
    end

    // Vector counter and error accumulators; the current vector's result is
    // folded in on the same edge that advances to the next vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_reg       <= '0;
            err_count_reg <= '0;
            err_sum_reg   <= '0;
            err_max_reg   <= '0;
            max_vec_reg   <= '0;
        end else if (start_go) begin
            vec_reg       <= '0;
            err_count_reg <= '0;
            err_sum_reg   <= '0;
            err_max_reg   <= '0;
            max_vec_reg   <= '0;
        end else if (accum) begin
            err_count_reg <= ACC_W'(sat_add(32'(err_count_reg), 32'(err != '0), ACC_W));
            err_sum_reg   <= ACC_W'(sat_add(32'(err_sum_reg), 32'(err), ACC_W));
            // Strict compare keeps the earliest vector on ties
            if (err > err_max_reg) begin
                err_max_reg <= err;
                max_vec_reg <= vec_reg;
            end
            if (!last_vec) begin
                vec_reg <= vec_reg + 1'b1;
            end
        end
    end

    assign op_a      = vec_reg[W-1:0];
    assign op_b      = vec_reg[2*W-1:W];
    assign err_count = err_count_reg;
    assign err_sum   = err_sum_reg;
    assign err_max   = err_max_reg;
    assign max_vec   = max_vec_reg;

endmodule

// File: tb/tb_abs_diff_err_sweep_ctrl.sv
// Self-checking bench for abs_diff_err_sweep_ctrl: drives full sweeps with
// several approximate-datapath behaviours and compares the accumulated
// metrics against a plain-arithmetic reference model.
module tb_abs_diff_err_sweep_ctrl;

    localparam int NVEC = 256;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic pause;
    logic abort;

    // 16-bit accumulator instance
    logic [3:0]  op_a, op_b, res_exact, res_apx, err_max;
    logic        busy, done;
    logic [15:0] err_count, err_sum;
    logic [7:0]  max_vec;

    // 8-bit accumulator instance (approximate result tied to zero)
    logic [3:0]  op_a_s, op_b_s, res_exact_s, err_max_s;
    logic [3:0]  res_apx_s;
    logic        busy_s, done_s;
    logic [7:0]  err_count_s, err_sum_s;
    logic [7:0]  max_vec_s;

    logic [1:0]  mode;
    logic [3:0]  lut [NVEC];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    abs_diff_err_sweep_ctrl #(.W(4), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .op_a(op_a), .op_b(op_b), .res_exact(res_exact), .res_apx(res_apx),
        .busy(busy), .done(done), .err_count(err_count), .err_sum(err_sum),
        .err_max(err_max), .max_vec(max_vec)
    );

    abs_diff_err_sweep_ctrl #(.W(4), .ACC_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .op_a(op_a_s), .op_b(op_b_s), .res_exact(res_exact_s), .res_apx(res_apx_s),
        .busy(busy_s), .done(done_s), .err_count(err_count_s), .err_sum(err_sum_s),
        .err_max(err_max_s), .max_vec(max_vec_s)
    );

    // Exact and approximate datapaths seen by the controllers
    always_comb begin
        res_exact   = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        res_exact_s = (op_a_s >= op_b_s) ? (op_a_s - op_b_s) : (op_b_s - op_a_s);
        res_apx_s   = 4'd0;
        case (mode)
            2'd0:    res_apx = res_exact;
            2'd1:    res_apx = res_exact ^ 4'd1;
            2'd2:    res_apx = 4'd0;
            default: res_apx = lut[{op_b, op_a}];
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: metrics over vectors 0..nvec-1 for approximate behaviour m
    task automatic model(input int m, input int nvec, input int accw,
                         output int cnt, output int sum, output int mx, output int mv);
        int cap;
        cap = (1 << accw) - 1;
        cnt = 0; sum = 0; mx = 0; mv = 0;
        for (int v = 0; v < nvec; v++) begin
            int a, b, ex, ap, e;
            a  = v % 16;
            b  = v / 16;
            ex = abs_i(a - b);
            case (m)
                0:       ap = ex;
                1:       ap = ex ^ 1;
                2:       ap = 0;
                default: ap = int'(lut[v]);
            endcase
            e = abs_i(ex - ap);
            if (e != 0 && cnt < cap) cnt++;
            sum = (sum + e > cap) ? cap : sum + e;
            if (e > mx) begin
                mx = e;
                mv = v;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_metrics(input string tag, input int nvec);
        int cnt, sum, mx, mv;
        model(int'(mode), nvec, 16, cnt, sum, mx, mv);
        check_val({tag, "_count"},   32'(err_count), 32'(cnt));
        check_val({tag, "_sum"},     32'(err_sum),   32'(sum));
        check_val({tag, "_max"},     32'(err_max),   32'(mx));
        check_val({tag, "_max_vec"}, 32'(max_vec),   32'(mv));
        $display("%s: count=%0d sum=%0d max=%0d max_vec=0x%02h", tag, err_count, err_sum, err_max, max_vec);
    endtask

    // Pulse start, then run until done. pmode: 0 none, 1 toggle, 2 random.
    // poke >= 0 re-asserts start at that sweep cycle (must be ignored).
    task automatic run_sweep(input int pmode, input int poke, output int cycles, output int paused);
        cycles = 0;
        paused = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            case (pmode)
                1:       pause = (i % 2 == 0);
                2:       pause = ($urandom_range(0, 3) == 0);
                default: pause = 1'b0;
            endcase
            start = (i == poke);
            if (pause) paused++;
            step();
            cycles = i + 1;
            if (done) break;
        end
        pause = 1'b0;
        start = 1'b0;
        if (!done) check_val("sweep_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int cyc, np;
        int cnt, sum, mx, mv;

        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; mode = 2'd0;
        for (int i = 0; i < NVEC; i++) lut[i] = 4'd0;
        repeat (3) step();
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_done",  32'(done),      32'd0);
        check_val("rst_count", 32'(err_count), 32'd0);
        check_val("rst_ops",   32'({op_b, op_a}), 32'd0);
        rst = 1'b0;
        step();

        // Case 1: approximate equals exact
        mode = 2'd0;
        run_sweep(0, -1, cyc, np);
        check_val("c1_cycles", 32'(cyc), 32'd256);
        check_metrics("c1", NVEC);

        // Case 2: LSB always wrong, with an ignored start mid-sweep
        mode = 2'd1;
        run_sweep(0, 40, cyc, np);
        check_val("c2_cycles", 32'(cyc), 32'd256);
        check_metrics("c2", NVEC);

        // Case 3: approximate result stuck at zero
        mode = 2'd2;
        run_sweep(0, -1, cyc, np);
        check_val("c3_cycles", 32'(cyc), 32'd256);
        check_metrics("c3", NVEC);
        check_val("c3_count_lit", 32'(err_count), 32'd240);
        check_val("c3_sum_lit",   32'(err_sum),   32'd1360);
        check_val("c3_maxvec_lit", 32'(max_vec),  32'h0F);
        // Narrow accumulator saturates on the same sweep
        check_val("s8_sum",     32'(err_sum_s),   32'd255);
        check_val("s8_count",   32'(err_count_s), 32'd240);
        check_val("s8_max",     32'(err_max_s),   32'd15);
        check_val("s8_max_vec", 32'(max_vec_s),   32'h0F);

        // Case 4: pause every other cycle doubles the latency only
        run_sweep(1, -1, cyc, np);
        check_val("c4_cycles", 32'(cyc), 32'd512);
        check_metrics("c4", NVEC);

        // Case 5: abort after 100 accumulated vectors, then a clean sweep
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("c5_busy", 32'(busy), 32'd0);
        check_val("c5_done", 32'(done), 32'd0);
        check_metrics("c5_abort", 100);
        step();
        check_val("c5_idle_busy", 32'(busy), 32'd0);
        run_sweep(0, -1, cyc, np);
        check_val("c5_cycles", 32'(cyc), 32'd256);
        check_metrics("c5", NVEC);

        // Randomized approximate datapaths with random pausing
        mode = 2'd3;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NVEC; i++) begin
                int ex;
                ex = abs_i((i % 16) - (i / 16));
                lut[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(ex);
            end
            run_sweep(2, -1, cyc, np);
            check_val($sformatf("rnd%0d_cycles", r), 32'(cyc), 32'(NVEC + np));
            check_metrics($sformatf("rnd%0d", r), NVEC);
        end

        // Random abort point against the partial-sweep model
        begin
            int k;
            k = int'($urandom_range(1, 250));
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (k) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            check_val("rabort_busy", 32'(busy), 32'd0);
            check_metrics($sformatf("rabort_k%0d", k), k);
        end

        // Asynchronous reset mid-sweep clears outputs without a clock edge
        mode = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy",  32'(busy),      32'd0);
        check_val("arst_count", 32'(err_count), 32'd0);
        check_val("arst_sum",   32'(err_sum),   32'd0);
        check_val("arst_max",   32'(err_max),   32'd0);
        check_val("arst_vec",   32'({op_b, op_a}), 32'd0);
        check_val("arst_s_sum", 32'(err_sum_s), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Sweep after reset still saturates the narrow accumulator
        run_sweep(0, -1, cyc, np);
        model(2, NVEC, 8, cnt, sum, mx, mv);
        check_val("post_s8_sum",   32'(err_sum_s),   32'(sum));
        check_val("post_s8_count", 32'(err_count_s), 32'(cnt));
        check_metrics("post", NVEC);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
